// File: rtl/snow_motion.sv
// Snowflake sprite position (snow_r, snow_c), stepped at vertical-blank start every FRAME_DIV frames.
// Registered outputs, no backpressure. run=0 freezes motion. Define SNOW_RANDOM_EN to randomise the respawn column.
module snow_motion #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int SPRITE_W   = 25,
   parameter int SPRITE_H   = 17,
   parameter int FRAME_DIV  = 2,
   parameter int FALL_STEP  = 1,
   parameter int DRIFT_STEP = 1,
   parameter int SWAY_LEN   = 8,
   parameter int START_C    = 300
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] row,
   input  logic [10:0] col,
   input  logic        run,
   output logic [10:0] snow_r,
   output logic [10:0] snow_c,
   output logic        frame_tick,
   output logic        wrap
);
   localparam int COL_MAX = H_ACTIVE - SPRITE_W;
   localparam int ROW_MAX = V_ACTIVE - SPRITE_H;
   localparam int FW      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int SW      = (SWAY_LEN > 1) ? $clog2(SWAY_LEN) : 1;

   typedef enum logic [1:0] {
      FALL_R = 2'd0,
      FALL_L = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t        state;
   logic          dir;
   logic [FW-1:0] frame_cnt;
   logic [SW-1:0] sway_cnt;

   logic          vb_start;
   logic          last_frame;
   logic          go_left;
   logic          respawn;
   logic          hit_r;
   logic          hit_l;
   logic          sway_done;
   logic [11:0]   r_step;
   logic [11:0]   c_right;
   logic [10:0]   c_left;
   logic [10:0]   spawn_c;

   assign vb_start   = (row == 11'(V_ACTIVE)) && (col == 11'd0);
   assign last_frame = (frame_cnt == FW'(FRAME_DIV - 1));
   assign sway_done  = (sway_cnt == SW'(SWAY_LEN - 1));

   // HOLD has no direction of its own; resume uses the saved one.
   assign go_left    = (state == HOLD) ? dir : (state == FALL_L);

   assign r_step     = {1'b0, snow_r} + 12'(FALL_STEP);
   assign respawn    = r_step > 12'(ROW_MAX);
   assign c_right    = {1'b0, snow_c} + 12'(DRIFT_STEP);
   assign hit_r      = c_right > 12'(COL_MAX);
   assign hit_l      = snow_c < 11'(DRIFT_STEP);
   assign c_left     = snow_c - 11'(DRIFT_STEP);

`ifdef SNOW_RANDOM_EN
   logic [15:0] lfsr;
   logic [10:0] rnd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   // Fold 0..1023 into 0..COL_MAX with a single subtraction.
   assign rnd     = {1'b0, lfsr[9:0]};
   assign spawn_c = (rnd > 11'(COL_MAX)) ? (rnd - 11'(COL_MAX + 1)) : rnd;
`else
   assign spawn_c = 11'(START_C);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snow_r     <= '0;
         snow_c     <= 11'(START_C);
         frame_tick <= 1'b0;
         wrap       <= 1'b0;
         state      <= FALL_R;
         dir        <= 1'b0;
         frame_cnt  <= '0;
         sway_cnt   <= '0;
      end else begin
         frame_tick <= vb_start;
         wrap       <= 1'b0;
         if (vb_start) begin
            if (!run) begin
               if (state != HOLD) begin
                  state <= HOLD;
                  dir   <= (state == FALL_L);
               end
            end else if (!last_frame) begin
               frame_cnt <= frame_cnt + FW'(1);
               if (state == HOLD) begin
                  state <= dir ? FALL_L : FALL_R;
               end
            end else begin
               frame_cnt <= '0;
               if (respawn) begin
                  snow_r   <= '0;
                  snow_c   <= spawn_c;
                  wrap     <= 1'b1;
                  state    <= FALL_R;
                  sway_cnt <= '0;
               end else begin
                  snow_r <= r_step[10:0];
                  if (!go_left) begin
                     if (hit_r) begin
                        snow_c   <= 11'(COL_MAX);
                        state    <= FALL_L;
                        sway_cnt <= '0;
                     end else begin
                        snow_c <= c_right[10:0];
                        if (sway_done) begin
                           state    <= FALL_L;
                           sway_cnt <= '0;
                        end else begin
                           state    <= FALL_R;
                           sway_cnt <= sway_cnt + SW'(1);
                        end
                     end
                  end else begin
                     if (hit_l) begin
                        snow_c   <= '0;
                        state    <= FALL_R;
                        sway_cnt <= '0;
                     end else begin
                        snow_c <= c_left;
                        if (sway_done) begin
                           state    <= FALL_R;
                           sway_cnt <= '0;
                        end else begin
                           state    <= FALL_L;
                           sway_cnt <= sway_cnt + SW'(1);
                        end
                     end
                  end
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_snow_motion.sv
// Bench for snow_motion: per-frame expectations queued when a blanking pulse is driven, checked on frame_tick.
module tb_snow_motion;
   localparam int V_ACTIVE = 480;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        run   = 1'b0;
   logic [10:0] row   = '0;
   logic [10:0] col   = '0;
   logic [10:0] snow_r, snow_c, r2, c2;
   logic        frame_tick, wrap, ft2, w2;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [10:0] r;
      logic [10:0] c;
      logic        w;
      logic        anyc;
   } exp_t;

   typedef struct {
      logic        run;
      logic [10:0] r;
      logic [10:0] c;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[40];

   always #5 clk = ~clk;

   snow_motion dut (
      .clk(clk), .rst_n(rst_n), .row(row), .col(col), .run(run),
      .snow_r(snow_r), .snow_c(snow_c), .frame_tick(frame_tick), .wrap(wrap)
   );

   snow_motion #(.START_C(614)) dut2 (
      .clk(clk), .rst_n(rst_n), .row(row), .col(col), .run(run),
      .snow_r(r2), .snow_c(c2), .frame_tick(ft2), .wrap(w2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Column after u updates from 300: eight steps right, eight steps left, repeating.
   function automatic int sway_c(input int u);
      int m;
      m = u % 16;
      return 300 + ((m <= 8) ? m : 16 - m);
   endfunction

   always @(negedge clk) begin
      if (frame_tick) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_tick: got frame_tick=1 at %0t, want no tick", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("snow_r", snow_r, e.r);
            if (e.anyc) check("respawn_c_range", (snow_c <= 11'd615), 1);
            else        check("snow_c", snow_c, e.c);
            check("wrap", wrap, e.w);
         end
      end
   end

   task automatic frame(input logic r, input bit push, input logic [10:0] er,
                        input logic [10:0] ec, input logic ew);
      exp_t e;
      @(negedge clk);
      run = r;
      row = 11'(V_ACTIVE);
      col = '0;
      if (push) begin
         e.r = er;
         e.c = ec;
         e.w = ew;
`ifdef SNOW_RANDOM_EN
         e.anyc = ew;
`else
         e.anyc = 1'b0;
`endif
         sb.push_back(e);
      end
      @(negedge clk);
      row = '0;
      col = 11'd5;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_snow_r", snow_r, 0);
      check("rst_snow_c", snow_c, 300);
      check("rst_frame_tick", frame_tick, 0);
      check("rst_wrap", wrap, 0);
      check("rst2_state", {r2, c2, ft2, w2}, {11'd0, 11'd614, 1'b0, 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int   u;
      bit   ph;
      logic rr;

      // Frames 19-22 freeze; motion then resumes with the same sway phase.
      u  = 0;
      ph = 1'b0;
      for (int i = 0; i < 40; i++) begin
         rr = !(i >= 18 && i < 22);
         if (rr) begin
            if (ph) begin
               u++;
               ph = 1'b0;
            end else begin
               ph = 1'b1;
            end
         end
         tbl[i].run = rr;
         tbl[i].r   = 11'(u);
         tbl[i].c   = 11'(sway_c(u));
      end

      do_reset();
      for (int i = 0; i < 40; i++) frame(tbl[i].run, 1'b1, tbl[i].r, tbl[i].c, 1'b0);

      // Right-edge clamp on the START_C=614 instance.
      do_reset();
      for (int f = 1; f <= 6; f++) begin
         frame(1'b1, 1'b1, 11'(f / 2), 11'(sway_c(f / 2)), 1'b0);
         if (f % 2 == 0) check("clamp_c", c2, (f == 6) ? 614 : 615);
      end

      // Fall all the way down and respawn.
      do_reset();
      for (int f = 1; f <= 928; f++) begin
         u = f / 2;
         if (u == 464) frame(1'b1, 1'b1, 11'd0, 11'd300, 1'b1);
         else          frame(1'b1, 1'b1, 11'(u), 11'(sway_c(u)), 1'b0);
      end
      check("wrap_one_cycle", wrap, 0);

      // Asynchronous reset in the cycle frame_tick is high, snow_r=200.
      do_reset();
      for (int f = 1; f <= 399; f++) begin
         u = f / 2;
         frame(1'b1, 1'b1, 11'(u), 11'(sway_c(u)), 1'b0);
      end
      @(negedge clk);
      run = 1'b1;
      row = 11'(V_ACTIVE);
      col = '0;
      @(posedge clk);
      #1;
      check("pre_rst_tick", frame_tick, 1);
      check("pre_rst_r", snow_r, 200);
      row = '0;
      col = 11'd37;
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_r", snow_r, 0);
      check("async_rst_c", snow_c, 300);
      check("async_rst_tick", frame_tick, 0);
      @(negedge clk);
      rst_n = 1'b1;
      frame(1'b1, 1'b1, 11'd0, 11'd300, 1'b0);
      frame(1'b1, 1'b1, 11'd1, 11'd301, 1'b0);

      repeat (4) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
